// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;
  localparam int unsigned CODE_W  = 4;

  // Scanner control states
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Codes for the non-digit keys
  localparam logic [CODE_W-1:0] KEY_A    = 4'hA;
  localparam logic [CODE_W-1:0] KEY_B    = 4'hB;
  localparam logic [CODE_W-1:0] KEY_C    = 4'hC;
  localparam logic [CODE_W-1:0] KEY_D    = 4'hD;
  localparam logic [CODE_W-1:0] KEY_STAR = 4'hE;
  localparam logic [CODE_W-1:0] KEY_HASH = 4'hF;

  // Column 0 driven low out of reset
  localparam logic [KP_COLS-1:0] COL_INIT = 4'b1110;

  // Move the single active-low column one position up, wrapping 3 -> 0
  function automatic logic [KP_COLS-1:0] col_rotl(input logic [KP_COLS-1:0] c);
    return {c[KP_COLS-2:0], c[KP_COLS-1]};
  endfunction

endpackage

// File: rtl/key_map.sv
// Combinational translation of (row, column) position to the key code.
module key_map
  import keypad_pkg::*;
(
  input  logic [1:0]        row,
  input  logic [1:0]        col,
  output logic [CODE_W-1:0] code
);

  // Physical layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  always_comb begin
    code = 4'h0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_D;
      default:  code = 4'h0;
    endcase
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press and release debouncing.
// Columns are strobed active-low one at a time; rows are sampled once per
// column dwell through a 2-flop synchronizer.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [3:0]  num,
  output logic        kpr,
  output logic        key_valid
);

  localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned LCNT_W = 3;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CNT);
  localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);
  localparam logic              ONE_SHOT = (DEBOUNCE_CNT == 1);

  logic [KP_ROWS-1:0] row_s1;
  logic [KP_ROWS-1:0] row_s2;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;

  state_t             state,    state_d;
  logic [DCNT_W-1:0]  dcnt,     dcnt_d;
  logic [1:0]         cand_row, cand_row_d;
  logic [3:0]         col_n_d;
  logic [3:0]         num_d;
  logic               kpr_d;
  logic               key_valid_d;

  logic [LCNT_W-1:0]  low_cnt;
  logic               hit;
  logic               idle;
  logic [1:0]         row_idx;
  logic [1:0]         col_idx;
  logic [DCNT_W-1:0]  dcnt_inc;
  logic [CODE_W-1:0]  key_code;

  // Two-flop synchronizer for the asynchronous row pins (idle = all high)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  // Column dwell divider, free-running in every state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Classify synchronized rows: one low is a hit, none low is idle
  always_comb begin
    low_cnt = '0;
    row_idx = 2'd0;
    for (int i = 0; i < int'(KP_ROWS); i++) begin
      if (!row_s2[i]) begin
        low_cnt = low_cnt + LCNT_W'(1);
        row_idx = 2'(i);
      end
    end
  end

  assign hit  = (low_cnt == LCNT_W'(1));
  assign idle = (low_cnt == '0);

  // Position of the active-low column
  always_comb begin
    case (col_n)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Saturating debounce increment
  assign dcnt_inc = (dcnt == DCNT_MAX) ? dcnt : dcnt + DCNT_ONE;

  key_map u_key_map (
    .row  (row_idx),
    .col  (col_idx),
    .code (key_code)
  );

  // Next-state and next-output logic; nothing moves except on a sample tick
  always_comb begin
    state_d     = state;
    dcnt_d      = dcnt;
    cand_row_d  = cand_row;
    col_n_d     = col_n;
    num_d       = num;
    kpr_d       = kpr;
    key_valid_d = 1'b0;

    if (tick) begin
      case (state)
        SCAN: begin
          if (hit) begin
            cand_row_d = row_idx;
            if (ONE_SHOT) begin
              num_d       = key_code;
              kpr_d       = 1'b1;
              key_valid_d = 1'b1;
              dcnt_d      = '0;
              state_d     = HELD;
            end else begin
              dcnt_d  = DCNT_ONE;
              state_d = DEBOUNCE;
            end
          end else begin
            col_n_d = col_rotl(col_n);
          end
        end

        DEBOUNCE: begin
          if (hit && (row_idx == cand_row)) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc == DCNT_MAX) begin
              num_d       = key_code;
              kpr_d       = 1'b1;
              key_valid_d = 1'b1;
              dcnt_d      = '0;
              state_d     = HELD;
            end
          end else begin
            dcnt_d  = '0;
            col_n_d = col_rotl(col_n);
            state_d = SCAN;
          end
        end

        // Multi-row contact counts as still pressed here
        HELD: begin
          if (idle) begin
            if (ONE_SHOT) begin
              kpr_d   = 1'b0;
              dcnt_d  = '0;
              col_n_d = col_rotl(col_n);
              state_d = SCAN;
            end else begin
              dcnt_d  = DCNT_ONE;
              state_d = RELEASE;
            end
          end
        end

        RELEASE: begin
          if (idle) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc == DCNT_MAX) begin
              kpr_d   = 1'b0;
              dcnt_d  = '0;
              col_n_d = col_rotl(col_n);
              state_d = SCAN;
            end
          end else begin
            state_d = HELD;
          end
        end

        default: begin
          state_d = SCAN;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SCAN;
      dcnt      <= '0;
      cand_row  <= 2'd0;
      col_n     <= COL_INIT;
      num       <= 4'h0;
      kpr       <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_d;
      dcnt      <= dcnt_d;
      cand_row  <= cand_row_d;
      col_n     <= col_n_d;
      num       <= num_d;
      kpr       <= kpr_d;
      key_valid <= key_valid_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with a behavioural switch-matrix model.
`timescale 1ns/1ps
module tb_keypad_scan;

  logic       clk;
  logic       reset_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] num;
  logic       kpr;
  logic       key_valid;

  // Keypad model: one pressed switch connects row pr to column pc
  logic       pressed;
  logic [1:0] pr;
  logic [1:0] pc;
  logic       ovr_en;
  logic [3:0] ovr;

  int n_chk  = 0;
  int n_fail = 0;
  int kv_count = 0;
  int exp_kv = 0;
  logic kv_prev = 1'b0;

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
  } vec_t;

  vec_t vecs [16];

  keypad_scan #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .num       (num),
    .kpr       (kpr),
    .key_valid (key_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    row_n = 4'hF;
    if (ovr_en) begin
      row_n = ovr;
    end else if (pressed && (col_n[pc] == 1'b0)) begin
      row_n[pr] = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Count strobes and make sure none lasts two clocks
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      kv_count++;
      chk("kv_single_cycle", 32'(kv_prev), 32'd0);
    end
    kv_prev = key_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_col_n", 32'(col_n), 32'hE);
    chk("rst_num", 32'(num), 32'h0);
    chk("rst_kpr", 32'(kpr), 32'd0);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_kv(input string name, input int max_cyc);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      step(1);
      got = key_valid;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic wait_kpr_low(input string name, input int max_cyc);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      step(1);
      got = !kpr;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{2'd3, 2'd2, 4'hF};
    vecs[1]  = '{2'd3, 2'd0, 4'hE};
    vecs[2]  = '{2'd3, 2'd3, 4'hD};
    vecs[3]  = '{2'd0, 2'd0, 4'h1};
    vecs[4]  = '{2'd0, 2'd1, 4'h2};
    vecs[5]  = '{2'd0, 2'd2, 4'h3};
    vecs[6]  = '{2'd0, 2'd3, 4'hA};
    vecs[7]  = '{2'd1, 2'd0, 4'h4};
    vecs[8]  = '{2'd1, 2'd1, 4'h5};
    vecs[9]  = '{2'd1, 2'd2, 4'h6};
    vecs[10] = '{2'd1, 2'd3, 4'hB};
    vecs[11] = '{2'd2, 2'd0, 4'h7};
    vecs[12] = '{2'd2, 2'd1, 4'h8};
    vecs[13] = '{2'd2, 2'd2, 4'h9};
    vecs[14] = '{2'd2, 2'd3, 4'hC};
    vecs[15] = '{2'd3, 2'd1, 4'h0};

    reset_n = 1'b0;
    pressed = 1'b0;
    pr      = 2'd0;
    pc      = 2'd0;
    ovr_en  = 1'b0;
    ovr     = 4'hF;

    // Idle scanning: column steps every 4 clocks
    do_reset();
    step(3);
    chk("scan_col_hold", 32'(col_n), 32'hE);
    step(1);
    chk("scan_col_1", 32'(col_n), 32'hD);
    step(4);
    chk("scan_col_2", 32'(col_n), 32'hB);
    step(4);
    chk("scan_col_3", 32'(col_n), 32'h7);
    step(4);
    chk("scan_col_wrap", 32'(col_n), 32'hE);

    // Key 5 held from reset: exact acceptance timing
    pr = 2'd1; pc = 2'd1; pressed = 1'b1;
    do_reset();
    step(15);
    chk("k5_kv_early", 32'(key_valid), 32'd0);
    chk("k5_col_held", 32'(col_n), 32'hD);
    chk("k5_kpr_early", 32'(kpr), 32'd0);
    step(1);
    chk("k5_kv", 32'(key_valid), 32'd1);
    chk("k5_num", 32'(num), 32'h5);
    chk("k5_kpr", 32'(kpr), 32'd1);
    exp_kv++;
    step(1);
    chk("k5_kv_drop", 32'(key_valid), 32'd0);
    chk("k5_col_still", 32'(col_n), 32'hD);

    // Release debounce: kpr falls on the third idle tick
    pressed = 1'b0;
    step(10);
    chk("rel_kpr_hold", 32'(kpr), 32'd1);
    chk("rel_num_hold", 32'(num), 32'h5);
    step(1);
    chk("rel_kpr_fall", 32'(kpr), 32'd0);
    chk("rel_col_next", 32'(col_n), 32'hB);
    chk("rel_num_keep", 32'(num), 32'h5);

    // Glitch during RELEASE returns to HELD and restarts release count
    pressed = 1'b1;
    wait_kv("glitch_press_kv", 60);
    exp_kv++;
    step(1);
    pressed = 1'b0;
    step(8);
    chk("glitch_kpr_pre", 32'(kpr), 32'd1);
    pressed = 1'b1;
    step(3);
    chk("glitch_kpr_held", 32'(kpr), 32'd1);
    pressed = 1'b0;
    step(11);
    chk("glitch_kpr_late", 32'(kpr), 32'd1);
    step(1);
    chk("glitch_kpr_fall", 32'(kpr), 32'd0);
    chk("glitch_col_next", 32'(col_n), 32'hB);

    // Bounce: key 6 seen for only two ticks is rejected
    pr = 2'd1; pc = 2'd2; pressed = 1'b1;
    step(8);
    pressed = 1'b0;
    step(3);
    chk("bounce_col_held", 32'(col_n), 32'hB);
    step(1);
    chk("bounce_col_resume", 32'(col_n), 32'h7);
    chk("bounce_kpr", 32'(kpr), 32'd0);
    chk("bounce_num", 32'(num), 32'h5);
    chk("bounce_kv_count", 32'(kv_count), 32'(exp_kv));

    // Two rows low in SCAN is treated as idle
    ovr = 4'b1001; ovr_en = 1'b1;
    step(40);
    chk("multi_kpr", 32'(kpr), 32'd0);
    chk("multi_kv_count", 32'(kv_count), 32'(exp_kv));
    ovr_en = 1'b0;
    step(8);

    // Every key position through press/release
    for (int i = 0; i < 16; i++) begin
      pr = vecs[i].r;
      pc = vecs[i].c;
      pressed = 1'b1;
      wait_kv($sformatf("tbl%0d_kv", i), 60);
      exp_kv++;
      chk($sformatf("tbl%0d_num", i), 32'(num), 32'(vecs[i].code));
      chk($sformatf("tbl%0d_kpr", i), 32'(kpr), 32'd1);
      pressed = 1'b0;
      wait_kpr_low($sformatf("tbl%0d_release", i), 40);
      chk($sformatf("tbl%0d_num_keep", i), 32'(num), 32'(vecs[i].code));
      chk($sformatf("tbl%0d_kv_count", i), 32'(kv_count), 32'(exp_kv));
    end

    // Asynchronous reset while held, then re-detection of the same key
    pr = 2'd1; pc = 2'd1; pressed = 1'b1;
    wait_kv("pre_reset_kv", 60);
    exp_kv++;
    step(2);
    do_reset();
    wait_kv("post_reset_kv", 60);
    exp_kv++;
    chk("post_reset_num", 32'(num), 32'h5);
    chk("post_reset_kpr", 32'(kpr), 32'd1);
    pressed = 1'b0;
    wait_kpr_low("post_reset_release", 40);
    step(2);
    chk("final_kv_count", 32'(kv_count), 32'(exp_kv));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
